// File: rtl/silife_max7219_sink_pkg.sv
// rtl/silife_max7219_sink_pkg.sv - MAX7219 register addresses and sink FSM state codes
package silife_max7219_sink_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/silife_max7219_sink_dev.sv
// rtl/silife_max7219_sink_dev.sv - register file of one chained MAX7219, written on a load strobe
module silife_max7219_sink_dev
  import silife_max7219_sink_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [15:0] i_word,
  output logic [63:0] o_digits,
  output logic [7:0]  o_decode,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_enabled,
  output logic        o_test
);

  logic [7:0][7:0] digits_q;
  logic [7:0]      decode_q;
  logic [3:0]      intensity_q;
  logic [2:0]      scan_q;
  logic            enabled_q;
  logic            test_q;

  logic [3:0] addr;
  logic [3:0] row;
  logic       unused_hi;

  assign addr      = i_word[11:8];
  assign row       = addr - REG_DIGIT0;
  // The top nibble of a MAX7219 word carries no meaning.
  assign unused_hi = ^{i_word[15:12], row[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q    <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      enabled_q   <= 1'b0;
      test_q      <= 1'b0;
    end else if (i_load) begin
      case (addr) inside
        [REG_DIGIT0:REG_DIGIT7]: digits_q[row[2:0]] <= i_word[7:0];
        REG_DECODE:              decode_q    <= i_word[7:0];
        REG_INTENSITY:           intensity_q <= i_word[3:0];
        REG_SCAN:                scan_q      <= i_word[2:0];
        REG_SHUTDOWN:            enabled_q   <= i_word[0];
        REG_TEST:                test_q      <= i_word[0];
        default:                 ;
      endcase
    end
  end

  assign o_digits     = digits_q;
  assign o_decode     = decode_q;
  assign o_intensity  = intensity_q;
  assign o_scan_limit = scan_q;
  assign o_enabled    = enabled_q;
  assign o_test       = test_q;

endmodule

// File: rtl/silife_max7219_sink.sv
// rtl/silife_max7219_sink.sv - behavioural receiver for a MAX7219 daisy chain with per-device readback
module silife_max7219_sink
  import silife_max7219_sink_pkg::*;
#(
  parameter  int NUM_DEVICES = 16,
  parameter  int CNT_BITS    = $clog2(16 * NUM_DEVICES) + 2,
  localparam int DEV_BITS    = $clog2(NUM_DEVICES),
  localparam int SHW         = 16 * NUM_DEVICES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_cs,
  input  logic                i_sck,
  input  logic                i_mosi,
  input  logic [DEV_BITS-1:0] i_rd_dev,
  input  logic [2:0]          i_rd_row,
  output logic [7:0]          o_rd_row_data,
  output logic [3:0]          o_rd_intensity,
  output logic [2:0]          o_rd_scan_limit,
  output logic [7:0]          o_rd_decode,
  output logic                o_rd_enabled,
  output logic                o_rd_test,
  output logic                o_frame_strobe,
  output logic                o_frame_error
);

  state_e              state_q;
  logic                cs_q;
  logic                sck_q;
  logic [SHW-1:0]      shreg_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                strobe_q;
  logic                error_q;

  logic cs_rise;
  logic sck_rise;
  logic load;

  assign cs_rise  = i_cs & ~cs_q;
  assign sck_rise = i_sck & ~sck_q;
  assign load     = (state_q == ST_SHIFT) & cs_rise;

  // IDLE needs CS high before arming, so a frame already in flight at reset release is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cs_q     <= 1'b0;
      sck_q    <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      cs_q     <= i_cs;
      sck_q    <= i_sck;
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cs) state_q <= ST_READY;
        end
        ST_READY: begin
          if (!i_cs) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state_q  <= ST_READY;
            strobe_q <= 1'b1;
            error_q  <= (cnt_q != CNT_BITS'(SHW));
          end else if (sck_rise) begin
            shreg_q <= {shreg_q[SHW-2:0], i_mosi};
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [63:0] dev_digits    [NUM_DEVICES];
  logic [7:0]  dev_decode    [NUM_DEVICES];
  logic [3:0]  dev_intensity [NUM_DEVICES];
  logic [2:0]  dev_scan      [NUM_DEVICES];
  logic        dev_enabled   [NUM_DEVICES];
  logic        dev_test      [NUM_DEVICES];

  for (genvar k = 0; k < NUM_DEVICES; k++) begin : g_dev
    silife_max7219_sink_dev u_dev (
      .clk          (clk),
      .reset        (reset),
      .i_load       (load),
      .i_word       (shreg_q[16*k +: 16]),
      .o_digits     (dev_digits[k]),
      .o_decode     (dev_decode[k]),
      .o_intensity  (dev_intensity[k]),
      .o_scan_limit (dev_scan[k]),
      .o_enabled    (dev_enabled[k]),
      .o_test       (dev_test[k])
    );
  end

  logic [7:0] rd_row_data_q;
  logic [3:0] rd_intensity_q;
  logic [2:0] rd_scan_q;
  logic [7:0] rd_decode_q;
  logic       rd_enabled_q;
  logic       rd_test_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_row_data_q  <= '0;
      rd_intensity_q <= '0;
      rd_scan_q      <= '0;
      rd_decode_q    <= '0;
      rd_enabled_q   <= 1'b0;
      rd_test_q      <= 1'b0;
    end else begin
      rd_row_data_q  <= dev_digits[i_rd_dev][{i_rd_row, 3'b000} +: 8];
      rd_intensity_q <= dev_intensity[i_rd_dev];
      rd_scan_q      <= dev_scan[i_rd_dev];
      rd_decode_q    <= dev_decode[i_rd_dev];
      rd_enabled_q   <= dev_enabled[i_rd_dev];
      rd_test_q      <= dev_test[i_rd_dev];
    end
  end

  assign o_rd_row_data   = rd_row_data_q;
  assign o_rd_intensity  = rd_intensity_q;
  assign o_rd_scan_limit = rd_scan_q;
  assign o_rd_decode     = rd_decode_q;
  assign o_rd_enabled    = rd_enabled_q;
  assign o_rd_test       = rd_test_q;
  assign o_frame_strobe  = strobe_q;
  assign o_frame_error   = error_q;

endmodule

// File: tb/tb_silife_max7219_sink.sv
// tb/tb_silife_max7219_sink.sv - self-checking bench for the MAX7219 chain receiver
module tb_silife_max7219_sink;

  localparam int N   = 16;
  localparam int SHW = 16 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_cs, i_sck, i_mosi;
  logic [3:0] i_rd_dev;
  logic [2:0] i_rd_row;
  logic [7:0] o_rd_row_data, o_rd_decode;
  logic [3:0] o_rd_intensity;
  logic [2:0] o_rd_scan_limit;
  logic       o_rd_enabled, o_rd_test, o_frame_strobe, o_frame_error;

  silife_max7219_sink dut (
    .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .i_rd_dev(i_rd_dev), .i_rd_row(i_rd_row),
    .o_rd_row_data(o_rd_row_data), .o_rd_intensity(o_rd_intensity),
    .o_rd_scan_limit(o_rd_scan_limit), .o_rd_decode(o_rd_decode),
    .o_rd_enabled(o_rd_enabled), .o_rd_test(o_rd_test),
    .o_frame_strobe(o_frame_strobe), .o_frame_error(o_frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the chain is a FIFO of the last SHW bits seen; device k owns the 16 bits
  // that sit 16*k positions back from the newest bit.
  bit         mq[$];
  logic [7:0] m_dig [N][8];
  logic [7:0] m_dec [N];
  logic [3:0] m_int [N];
  logic [2:0] m_scan[N];
  logic       m_en  [N];
  logic       m_test[N];
  int         m_cnt;
  bit         model_on;

  function automatic void model_reset();
    mq = {};
    for (int i = 0; i < SHW; i++) mq.push_back(1'b0);
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 8; r++) m_dig[k][r] = 8'h00;
      m_dec[k] = 8'h00; m_int[k] = 4'h0; m_scan[k] = 3'h0; m_en[k] = 1'b0; m_test[k] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_latch();
    logic [15:0] w;
    int a;
    for (int k = 0; k < N; k++) begin
      w = '0;
      for (int b = 0; b < 16; b++) w = {w[14:0], mq[SHW - 16 * (k + 1) + b]};
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8) m_dig[k][a - 1] = w[7:0];
      else if (a == 9)  m_dec[k]  = w[7:0];
      else if (a == 10) m_int[k]  = w[3:0];
      else if (a == 11) m_scan[k] = w[2:0];
      else if (a == 12) m_en[k]   = w[0];
      else if (a == 15) m_test[k] = w[0];
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    model_on = 1'b1;
    i_cs = 1'b1; i_sck = 1'b0; tick();
  endtask

  task automatic cs_low();
    i_cs = 1'b0; tick();
    m_cnt = 0;
  endtask

  task automatic send_bit(input bit b);
    i_mosi = b; i_sck = 1'b0; tick();
    i_sck = 1'b1; tick();
    if (model_on) begin
      mq.push_back(b); void'(mq.pop_front());
      m_cnt++;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic end_frame(input string name);
    logic exp_err;
    exp_err = (m_cnt != SHW);
    i_sck = 1'b0; tick();
    i_cs = 1'b1; tick();
    checks++;
    if (o_frame_strobe !== 1'b1) begin
      errors++; $display("FAIL %s strobe got %b want 1", name, o_frame_strobe);
    end
    checks++;
    if (o_frame_error !== exp_err) begin
      errors++; $display("FAIL %s frame_error got %b want %b", name, o_frame_error, exp_err);
    end
    model_latch();
    tick();
    checks++;
    if (o_frame_strobe !== 1'b0 || o_frame_error !== 1'b0) begin
      errors++; $display("FAIL %s pulse_width got %b%b want 00", name, o_frame_strobe, o_frame_error);
    end
  endtask

  task automatic rd(input int k, input int r);
    i_rd_dev = 4'(k); i_rd_row = 3'(r); tick();
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 8; r++) begin
        rd(k, r);
        checks++;
        if (o_rd_row_data !== m_dig[k][r]) begin
          errors++;
          $display("FAIL %s row dev%0d row%0d got %h want %h", name, k, r, o_rd_row_data, m_dig[k][r]);
        end
      end
      checks++;
      if ({o_rd_decode, o_rd_intensity, o_rd_scan_limit, o_rd_enabled, o_rd_test} !==
          {m_dec[k], m_int[k], m_scan[k], m_en[k], m_test[k]}) begin
        errors++;
        $display("FAIL %s ctrl dev%0d got dec=%h int=%h scan=%h en=%b test=%b want dec=%h int=%h scan=%h en=%b test=%b",
                 name, k, o_rd_decode, o_rd_intensity, o_rd_scan_limit, o_rd_enabled, o_rd_test,
                 m_dec[k], m_int[k], m_scan[k], m_en[k], m_test[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_cs = 1'b1; i_sck = 1'b0; i_mosi = 1'b0; i_rd_dev = '0; i_rd_row = '0;
    tick(); tick();
    do_reset();
    checks++;
    if ({o_frame_strobe, o_frame_error, o_rd_row_data, o_rd_intensity, o_rd_scan_limit,
         o_rd_decode, o_rd_enabled, o_rd_test} !== '0) begin
      errors++; $display("FAIL reset outputs got nonzero want all 0");
    end
    check_regs("reset_regs");
  endtask

  task automatic test_intensity();
    cs_low();
    for (int j = 0; j < N; j++) send_word(16'h0A05);
    end_frame("intensity");
    rd(0, 0);
    checks++;
    if (o_rd_intensity !== 4'h5) begin errors++; $display("FAIL intensity dev0 got %h want 5", o_rd_intensity); end
    rd(15, 0);
    checks++;
    if (o_rd_intensity !== 4'h5) begin errors++; $display("FAIL intensity dev15 got %h want 5", o_rd_intensity); end
    check_regs("intensity_regs");
  endtask

  task automatic test_digit_order();
    cs_low();
    for (int j = 0; j < N; j++) send_word(16'h0100 + 16'(j));
    end_frame("order");
    rd(15, 0); checks++;
    if (o_rd_row_data !== 8'h00) begin errors++; $display("FAIL order dev15 got %h want 00", o_rd_row_data); end
    rd(0, 0); checks++;
    if (o_rd_row_data !== 8'h0F) begin errors++; $display("FAIL order dev0 got %h want 0f", o_rd_row_data); end
    rd(7, 0); checks++;
    if (o_rd_row_data !== 8'h08) begin errors++; $display("FAIL order dev7 got %h want 08", o_rd_row_data); end
  endtask

  task automatic test_noop();
    cs_low();
    for (int j = 0; j < N; j++) send_word(16'h01AA);
    end_frame("preload");
    cs_low();
    for (int j = N - 1; j >= 0; j--) send_word(j == 3 ? 16'h0000 : 16'h0155);
    end_frame("noop");
    rd(3, 0); checks++;
    if (o_rd_row_data !== 8'hAA) begin errors++; $display("FAIL noop dev3 got %h want aa", o_rd_row_data); end
    rd(4, 0); checks++;
    if (o_rd_row_data !== 8'h55) begin errors++; $display("FAIL noop dev4 got %h want 55", o_rd_row_data); end
    check_regs("noop_regs");
  endtask

  task automatic test_short_frame();
    cs_low();
    for (int j = 0; j < N; j++) send_word(16'h0B07);
    end_frame("scan_full");
    cs_low();
    for (int j = 0; j < 8; j++) send_word(16'h0C01);
    end_frame("short");
    rd(0, 0); checks++;
    if (o_rd_enabled !== 1'b1) begin errors++; $display("FAIL short dev0 enabled got %b want 1", o_rd_enabled); end
    rd(8, 0); checks++;
    if ({o_rd_scan_limit, o_rd_enabled} !== {3'd7, 1'b0}) begin
      errors++; $display("FAIL short dev8 scan/en got %h/%b want 7/0", o_rd_scan_limit, o_rd_enabled);
    end
    check_regs("short_regs");
  endtask

  task automatic test_reset_mid_frame();
    cs_low();
    for (int i = 0; i < 100; i++) send_bit(1'($urandom));
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    model_on = 1'b0;
    for (int i = 0; i < 156; i++) send_bit(1'($urandom));
    i_sck = 1'b0; tick();
    i_cs = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); checks++;
      if (o_frame_strobe !== 1'b0) begin errors++; $display("FAIL midreset strobe cyc%0d got 1 want 0", c); end
    end
    model_on = 1'b1;
    check_regs("midreset_regs");
    cs_low();
    for (int j = 0; j < N; j++) send_word({4'h0, 4'($urandom_range(1, 12)), 8'($urandom)});
    end_frame("after_reset");
    check_regs("after_reset_regs");
  endtask

  task automatic test_cs_sck_collision();
    cs_low();
    for (int i = 0; i < SHW - 1; i++) send_bit(1'($urandom));
    i_mosi = 1'b1; i_sck = 1'b0; tick();
    i_sck = 1'b1; i_cs = 1'b1; tick();
    checks++;
    if (o_frame_strobe !== 1'b1 || o_frame_error !== 1'b1) begin
      errors++; $display("FAIL collision strobe/err got %b%b want 11", o_frame_strobe, o_frame_error);
    end
    model_latch();
    i_sck = 1'b0; tick();
    check_regs("collision_regs");
  endtask

  task automatic test_random_frames();
    int lens[6];
    lens = '{SHW, 0, SHW, 37, SHW + 16, SHW};
    for (int f = 0; f < 6; f++) begin
      cs_low();
      for (int i = 0; i < lens[f]; i++) send_bit(1'($urandom));
      end_frame($sformatf("rand%0d", f));
      check_regs($sformatf("rand%0d_regs", f));
    end
  endtask

  initial begin
    test_reset();
    test_intensity();
    test_digit_order();
    test_noop();
    test_short_frame();
    test_reset_mid_frame();
    test_cs_sck_collision();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
